// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D).
// One access in flight at a time; data wins ties, bounded by a D-grant streak limit.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    state_t        state;
    logic          owner_d;
    logic [SW-1:0] streak;
    logic          grant_d;

    // Data wins ties until it has taken STREAK_MAX grants in a row over a waiting fetch.
    assign grant_d   = d_req && (!i_req || (streak < STREAK_MAX));
    assign stall_if  = i_req & ~i_done;
    assign stall_mem = d_req & ~d_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b1;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    if (d_req || i_req) begin
                        owner_d <= grant_d;
                        mem_req <= 1'b1;
                        state   <= ACCESS;
                        if (grant_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_we ? d_wdata : '0;
                            streak    <= i_req ? streak + SW'(1) : '0;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            streak    <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                        if (owner_d) begin
                            if (!mem_we) d_rdata <= mem_rdata;
                            d_done <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    i_done <= 1'b0;
                    d_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie, starvation bound, slow memory,
// store and mid-access reset, with hand-computed cycle expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if ({i_done, d_done} !== 2'b00) begin errors++; $display("FAIL rst_done: got %b expected 00", {i_done, d_done}); end
        checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h expected 0/0", i_rdata, d_rdata); end
        checks++; if ({stall_if, stall_mem} !== 2'b00) begin errors++; $display("FAIL rst_stall: got %b expected 00", {stall_if, stall_mem}); end
    endtask

    task automatic test_fetch();
        do_reset();
        i_req = 1; i_addr = 32'h10; mem_ready = 1; mem_rdata = 32'h00500093;
        #1;
        checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall_t0: got %b expected 1", stall_if); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_t1: got req=%b addr=%h we=%b expected 1/00000010/0", mem_req, mem_addr, mem_we); end
        @(negedge clk);
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_t2: got done=%b rdata=%h expected 1/00500093", i_done, i_rdata); end
        checks++; if (stall_if !== 1'b0 || d_done !== 1'b0) begin errors++; $display("FAIL fetch_t2_stall: got stall_if=%b d_done=%b expected 0/0", stall_if, d_done); end
        i_req = 0;
        @(negedge clk);
        checks++; if (i_done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL fetch_t3: got done=%b req=%b expected 0/0", i_done, mem_req); end
    endtask

    task automatic test_tie();
        do_reset();
        i_req = 1; i_addr = 32'h14;
        d_req = 1; d_we = 0; d_addr = 32'h40; d_wdata = 32'h55555555;
        mem_ready = 1; mem_rdata = 32'h0000002A;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL tie_t1: got addr=%h wdata=%h we=%b expected 00000040/0/0", mem_addr, mem_wdata, mem_we); end
        @(negedge clk);
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h2A || i_done !== 1'b0) begin errors++; $display("FAIL tie_t2: got d_done=%b d_rdata=%h i_done=%b expected 1/0000002a/0", d_done, d_rdata, i_done); end
        d_req = 0; mem_rdata = 32'h00A00113;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tie_t3: got mem_req=%b expected 0", mem_req); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h14) begin errors++; $display("FAIL tie_t4: got req=%b addr=%h expected 1/00000014", mem_req, mem_addr); end
        @(negedge clk);
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h00A00113 || d_rdata !== 32'h2A) begin errors++; $display("FAIL tie_t5: got i_done=%b i_rdata=%h d_rdata=%h expected 1/00a00113/0000002a", i_done, i_rdata, d_rdata); end
        i_req = 0;
    endtask

    task automatic test_starvation();
        do_reset();
        i_req = 1; i_addr = 32'h100;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        mem_ready = 1; mem_rdata = 32'h77;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            checks++;
            if (d_done !== ((t == 2) || (t == 5) || (t == 8) || (t == 11))) begin
                errors++; $display("FAIL starve_d_done_t%0d: got %b expected %b", t, d_done, (t == 2) || (t == 5) || (t == 8) || (t == 11));
            end
            checks++;
            if (i_done !== (t == 14)) begin
                errors++; $display("FAIL starve_i_done_t%0d: got %b expected %b", t, i_done, t == 14);
            end
            if (t == 13) begin
                checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL starve_i_addr_t13: got %h expected 00000100", mem_addr); end
            end
            if (d_done === 1'b1) d_addr = d_addr + 32'h4;
        end
        i_req = 0; d_req = 0;
    endtask

    task automatic test_slow_mem();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h80; mem_ready = 0; mem_rdata = 32'hCAFEF00D;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0 || d_done !== 1'b0) begin
                errors++; $display("FAIL slow_hold_t%0d: got req=%b addr=%h we=%b done=%b expected 1/00000080/0/0", t, mem_req, mem_addr, mem_we, d_done);
            end
        end
        mem_ready = 1;
        @(negedge clk);
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL slow_done: got done=%b rdata=%h expected 1/cafef00d", d_done, d_rdata); end
        d_req = 0; mem_ready = 0;
        @(negedge clk);
        checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL slow_done_pulse: got %b expected 0", d_done); end
    endtask

    task automatic test_store();
        // Continues from test_slow_mem: d_rdata holds 0xCAFEF00D and the FSM is in IDLE.
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        mem_ready = 1; mem_rdata = 32'h13579BDF;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_t1: got req=%b we=%b addr=%h wdata=%h expected 1/1/00000020/deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'hCAFEF00D || mem_req !== 1'b0) begin errors++; $display("FAIL store_t2: got done=%b rdata=%h req=%b expected 1/cafef00d/0", d_done, d_rdata, mem_req); end
        d_req = 0; d_we = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h44; mem_ready = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        checks++; if (d_rdata !== 32'h12345678) begin errors++; $display("FAIL midrst_preload: got %h expected 12345678", d_rdata); end
        d_addr = 32'h48; mem_ready = 0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h48) begin errors++; $display("FAIL midrst_access: got req=%b addr=%h expected 1/00000048", mem_req, mem_addr); end
        rst = 1; d_req = 0; mem_ready = 1;
        #1;
        checks++; if (mem_req !== 1'b0 || d_done !== 1'b0 || d_rdata !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_async: got req=%b done=%b rdata=%h addr=%h expected 0/0/0/0", mem_req, d_done, d_rdata, mem_addr); end
        @(negedge clk);
        rst = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++; if ({mem_req, i_done, d_done} !== 3'b000) begin errors++; $display("FAIL midrst_quiet_%0d: got req/i/d=%b expected 000", t, {mem_req, i_done, d_done}); end
        end
        i_req = 1; i_addr = 32'h30; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h30) begin errors++; $display("FAIL midrst_new_req: got req=%b addr=%h expected 1/00000030", mem_req, mem_addr); end
        @(negedge clk);
        checks++; if (i_done !== 1'b1 || i_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL midrst_new_done: got done=%b rdata=%h expected 1/0badf00d", i_done, i_rdata); end
        i_req = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_tie();
        test_starvation();
        test_slow_mem();
        test_store();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
